wc_6_3_io_seq: RTL
==================

// Module: wc_6_3_io_seq
// PURPOSE
//  Pad-side sequencer for the WC_6_3 Winograd F(6,3) core. Deserialises one frame per tile from the
//  10-bit D pad bus (sync word, 3 filter taps g, 8 input samples d), pulses the core start, waits for
//  core done, then serialises the 6 results onto the 10-bit Z pad bus behind a header word.
//  Sits inside CHIP between the XMD/YA2GSD pads and the core; all core I/O is parallel.
// PARAMETERS
//  W        10      data word width (pad bus, taps, samples, results)
//  N_G      3       filter taps per frame
//  N_D      8       input samples per frame (N_Y+N_G-1)
//  N_Y      6       results per frame
//  SYNC     10'h3FF frame-start / result-header word
//  ERR      10'h3FE error header emitted on core timeout
//  TIMEOUT  64      max cycles in WAIT before abort
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst         in   1        synchronous active-high reset
//  D           in   W        pad input word, sampled every cycle
//  Z           out  W        pad output word, registered
//  g_out       out  N_G*W    tap bank, g[i] at [i*W +: W]
//  d_out       out  N_D*W    sample bank, d[i] at [i*W +: W]
//  core_start  out  1        one-cycle pulse, banks stable from here until done
//  core_done   in   1        core result valid, single-cycle pulse
//  y_in        in   N_Y*W    core results, y[i] at [i*W +: W], valid with core_done
//  busy        out  1        high in every state except IDLE
//  err         out  1        sticky timeout flag, cleared on next accepted SYNC
// BEHAVIOUR
//  Reset: state IDLE, cnt=0, Z=0, core_start=0, busy=0, err=0, g/d/y banks all zero.
//  States: IDLE, LOAD_G, LOAD_D, START, WAIT, SEND_HDR, SEND.
//  IDLE: Z=0. D==SYNC sampled -> LOAD_G, cnt=0, err<=0. Other D ignored.
//  LOAD_G: g[cnt]<=D each cycle; cnt==N_G-1 -> LOAD_D, cnt=0.
//  LOAD_D: d[cnt]<=D each cycle; cnt==N_D-1 -> START.
//   D==SYNC inside LOAD_* is payload, never a resync.
//  START: core_start=1 for exactly this cycle -> WAIT, timer=0.
//  WAIT: core_done=1 -> y bank<=y_in, -> SEND_HDR. Else timer++;
//   timer==TIMEOUT-1 without done -> Z<=ERR for one cycle, err<=1, -> IDLE.
//   Done and timeout in same cycle: done wins.
//  SEND_HDR: Z=SYNC for one cycle -> SEND, cnt=0.
//  SEND: Z=y[cnt], y[0] first; cnt==N_Y-1 -> IDLE (Z back to 0 next cycle).
//  Z is registered and updated on the same edge as the state change, so Z equals the
//   value of the state it is in (SYNC during SEND_HDR, y[k] during SEND cycle k).
//  core_done outside WAIT is ignored; y bank unchanged.
//  D is not sampled in START/WAIT/SEND*; a new frame needs SYNC after return to IDLE.
//  Latency: SYNC at cycle 0 -> g at 1..3, d at 4..11, core_start at 12, WAIT from 13.
//   done at cycle t -> header on Z at t+1, y[0..5] at t+2..t+7, IDLE (Z=0) at t+8.
//  g/d banks hold last frame until overwritten; outputs only change in LOAD_*.
//  Counters: cnt ceil(log2(N_D)) bits, timer ceil(log2(TIMEOUT)) bits, no wrap in use.
//  rst at any cycle (mid-load, WAIT, SEND) -> full reset values next cycle, partial frame dropped.
// TESTING
//  T1 nominal: SYNC, g=1,2,3, d=10..17, done 5 cyc after start, y=100..105 -> start@12,
//     Z: 3FF then 100..105 on 6 consecutive cycles, then 0; g_out/d_out match.
//  T2 no-SYNC: D=3FE,000,123 in IDLE -> stays IDLE, busy=0, Z=0, core_start never.
//  T3 SYNC as payload: frame with d[3]=3FF -> d_out[3]=3FF, core_start still at cycle 12.
//  T4 timeout: full frame, core_done never -> Z=3FE at WAIT cycle 64, err=1, IDLE;
//     next SYNC clears err.
//  T5 reset mid-op: rst in LOAD_D cnt=4 and again in SEND cnt=2 -> next cycle all reset
//     values, Z=0; following full frame runs as T1.
//  T6 spurious done: core_done pulsed in LOAD_G and SEND -> no state change, y bank unchanged.

Source files
------------

// File: rtl/wc_6_3_io_seq.sv
// Pad-side sequencer for the WC_6_3 Winograd F(6,3) core.
// Deserialises a SYNC-led frame (taps then samples) from the D pad bus into
// parallel banks, kicks the core, then serialises the results onto Z behind a
// header word. A core that never answers is abandoned after TIMEOUT cycles.
module wc_6_3_io_seq #(
  parameter int          W       = 10,
  parameter int          N_G     = 3,
  parameter int          N_D     = 8,
  parameter int          N_Y     = 6,
  parameter logic [W-1:0] SYNC   = 10'h3FF,
  parameter logic [W-1:0] ERR    = 10'h3FE,
  parameter int          TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     D,
  output logic [W-1:0]     Z,
  output logic [N_G*W-1:0] g_out,
  output logic [N_D*W-1:0] d_out,
  output logic             core_start,
  input  logic             core_done,
  input  logic [N_Y*W-1:0] y_in,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(N_D);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, LOAD_G, LOAD_D, START, WAIT, SEND_HDR, SEND
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_inc;
  logic [TW-1:0]  timer_q, timer_d;
  logic [W-1:0]   z_q, z_d;
  logic           err_q, err_d;
  logic [W-1:0]   g_q [N_G];
  logic [W-1:0]   g_d [N_G];
  logic [W-1:0]   d_q [N_D];
  logic [W-1:0]   d_d [N_D];
  logic [W-1:0]   y_q [N_Y];
  logic [W-1:0]   y_d [N_Y];

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state, bank capture and the Z word that goes with the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    z_d     = '0;
    err_d   = err_q;
    g_d     = g_q;
    d_d     = d_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (D == SYNC) begin
          state_d = LOAD_G;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD_G: begin
        for (int i = 0; i < N_G; i++)
          if (cnt_q == CW'(i)) g_d[i] = D;
        if (cnt_q == CW'(N_G - 1)) begin
          state_d = LOAD_D;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOAD_D: begin
        for (int i = 0; i < N_D; i++)
          if (cnt_q == CW'(i)) d_d[i] = D;
        if (cnt_q == CW'(N_D - 1)) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      START: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        if (core_done) begin
          for (int i = 0; i < N_Y; i++) y_d[i] = y_in[i*W +: W];
          state_d = SEND_HDR;
          z_d     = SYNC;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          z_d     = ERR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SEND_HDR: begin
        state_d = SEND;
        cnt_d   = '0;
        z_d     = y_q[0];
      end
      SEND: begin
        if (cnt_q == CW'(N_Y - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          for (int i = 0; i < N_Y; i++)
            if (cnt_inc == CW'(i)) z_d = y_q[i];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, banks and the registered Z word, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      g_q     <= '{default: '0};
      d_q     <= '{default: '0};
      y_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      z_q     <= z_d;
      err_q   <= err_d;
      g_q     <= g_d;
      d_q     <= d_d;
      y_q     <= y_d;
    end
  end

  // Flatten the tap and sample banks onto the parallel core ports.
  always_comb begin
    g_out = '0;
    d_out = '0;
    for (int i = 0; i < N_G; i++) g_out[i*W +: W] = g_q[i];
    for (int i = 0; i < N_D; i++) d_out[i*W +: W] = d_q[i];
  end

  assign Z          = z_q;
  assign err        = err_q;
  assign core_start = (state_q == START);
  assign busy       = (state_q != IDLE);

endmodule
